act_quant16: RTL
================

// Module: act_quant16
// PURPOSE
//  Downstream stage of the 16-tap accumulator: takes each 24-bit signed neuron sum,
//  requantizes it (rounded arithmetic right shift), applies ReLU and saturates to 8 bits.
//  Results are buffered in a small FIFO with a valid/ready output toward the next layer.
//  The producer has no backpressure: a sum arriving while the FIFO is full is dropped and flagged.
// PARAMETERS
//  IN_W   24  input sum width, two's complement
//  OUT_W  8   output activation width, two's complement
//  DEPTH  4   output FIFO entries; power of 2, >= 2
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      reset, asynchronous, active-high
//  sum_in     in   IN_W   signed accumulated sum
//  sum_valid  in   1      1-cycle strobe: sum_in valid this cycle
//  shift      in   5      right-shift amount; sampled with sum_valid; values >23 clamp to 23
//  out_data   out  OUT_W  FIFO head activation
//  out_valid  out  1      FIFO non-empty
//  out_ready  in   1      consumer accepts out_data when out_valid & out_ready
//  sat        out  1      1-cycle pulse when a result clipped at the positive or negative limit
//  ovf_drop   out  1      sticky: a result was dropped because the FIFO was full
// BEHAVIOUR
//  Reset: all outputs 0, pipeline valid bits 0, FIFO empty, pointers 0. Reset mid-operation
//   discards in-flight and buffered results; no output is produced from pre-reset data.
//  Stage 1 (edge after sum_valid): r = (sext25(sum_in) + (s>0 ? 1<<(s-1) : 0)) >>> s,
//   where s = clamped shift. Computed in 25 bits so the rounding add never wraps.
//   Rounding is round-half-up: 1.5 -> 2; -1.5 -> -1.
//  Stage 2: ReLU: r<0 -> 0. If r>127 -> 127 and sat=1. Result pushed into the FIFO.
//  Latency: sum_valid high in cycle t -> result in FIFO at edge t+2; out_valid=1 from
//   cycle t+2 when the FIFO was empty (show-ahead, out_data = head).
//  Throughput: 1 sum/cycle, fully pipelined; back-to-back strobes allowed.
//  Pop: on an edge with out_valid & out_ready, the head is removed.
//  Push while full: push succeeds only if a pop happens on the same edge. Otherwise the
//   result is dropped and ovf_drop is set; it stays 1 until rst.
//  Push and pop on the same edge with FIFO empty: no pop occurs. The result is written and
//   becomes visible the next cycle.
//  Occupancy counter is 0..DEPTH. Pointers wrap modulo DEPTH. Data order is strictly FIFO.
//  sat is registered alongside the stage-2 result. It pulses even if that result is later dropped.
// CONFIGURATION
//  ACT_LEAKY_EN defined: negative r is not zeroed; out = r >>> 3 (floor).
//   If the result is < -128, out = -128 and sat=1.
//  ACT_LEAKY_EN undefined: plain ReLU as above. Negative outputs never appear.
// TESTING
//  1 rst asserted mid-stream with 3 entries queued -> out_valid=0 and ovf_drop=0 at once;
//    after release, no stale data appears.
//  2 sum_in=384, shift=4, strobe at t, out_ready=1 -> out_data=24, out_valid=1 at cycle t+2.
//    Next cycle out_valid=0.
//  3 sum_in=24, shift=4 -> 2 (round half up). sum_in=23, shift=4 -> 1.
//  4 sum_in=-500 (0xFFFE0C), shift=2 -> 0 without ACT_LEAKY_EN. With it: r=-125 -> out=-16 (0xF0).
//  5 sum_in=100000, shift=0 -> out=127, sat pulses 1 cycle. sum_in=0x7FFFFF, shift=23 -> out=1.
//  6 out_ready=0, 5 back-to-back strobes of sums 1..5 (shift=0) -> 4 entries, ovf_drop=1.
//    Then out_ready=1 drains 1,2,3,4 in order, 1/cycle. Also check push while full with a
//    same-edge pop: no drop.

Source files
------------

// File: rtl/act_quant16.sv
// Requantizes 24-bit neuron sums (rounded arithmetic shift), applies ReLU with 8-bit
// saturation and buffers results in a show-ahead FIFO. Define ACT_LEAKY_EN for leaky ReLU.
module act_quant16 #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  sum_in,
  input  logic                    sum_valid,
  input  logic [4:0]              shift,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sat,
  output logic                    ovf_drop
);

  localparam int R_W   = IN_W + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [4:0] MAX_SHIFT = 5'(IN_W - 1);
  localparam logic signed [R_W-1:0] MAX_POS = R_W'(2 ** (OUT_W - 1) - 1);
`ifdef ACT_LEAKY_EN
  localparam logic signed [R_W-1:0] MIN_NEG = R_W'(-(2 ** (OUT_W - 1)));
`endif

  // One extra bit keeps the rounding bias add from wrapping near the positive limit.
  function automatic logic signed [R_W-1:0] round_shift(input logic signed [IN_W-1:0] x,
                                                        input logic [4:0] sh);
    logic [4:0]             s;
    logic signed [R_W-1:0]  bias;
    logic signed [R_W-1:0]  acc;
    s    = (sh > MAX_SHIFT) ? MAX_SHIFT : sh;
    bias = '0;
    if (s != 5'd0)
      bias = R_W'(1) << (s - 5'd1);
    acc = {x[IN_W-1], x} + bias;
    return acc >>> s;
  endfunction

  // Returns {clipped, activation}.
  function automatic logic [OUT_W:0] activate(input logic signed [R_W-1:0] r);
    logic signed [R_W-1:0] v;
    logic                  clip;
    v    = r;
    clip = 1'b0;
    if (r > MAX_POS) begin
      v    = MAX_POS;
      clip = 1'b1;
    end else if (r < 0) begin
`ifdef ACT_LEAKY_EN
      v = r >>> 3;
      if (v < MIN_NEG) begin
        v    = MIN_NEG;
        clip = 1'b1;
      end
`else
      v = '0;
`endif
    end
    return {clip, v[OUT_W-1:0]};
  endfunction

  logic signed [R_W-1:0]  r_p1_d, r_p1_q;
  logic                   vld_p1_d, vld_p1_q;
  logic [OUT_W:0]         act_p2;
  logic                   sat_d, sat_q;
  logic                   ovf_d, ovf_q;
  logic [PTR_W-1:0]       wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CNT_W-1:0]       cnt_d, cnt_q;
  logic                   pop, full, push_ok, drop;
  logic signed [OUT_W-1:0] mem_q [DEPTH];

  // Stage 1: rounded requantization of the incoming sum.
  always_comb begin
    r_p1_d   = round_shift(sum_in, shift);
    vld_p1_d = sum_valid;
  end

  always_ff @(posedge clk) r_p1_q <= r_p1_d;

  // Stage 2: activation, saturation and FIFO push.
  always_comb begin
    act_p2   = activate(r_p1_q);
    pop      = out_valid & out_ready;
    full     = (cnt_q == CNT_W'(DEPTH));
    push_ok  = vld_p1_q & (~full | pop);
    drop     = vld_p1_q & full & ~pop;
    sat_d    = vld_p1_q & act_p2[OUT_W];
    ovf_d    = ovf_q | drop;
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q + CNT_W'(push_ok) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      sat_q    <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      sat_q    <= sat_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wr_ptr_q] <= act_p2[OUT_W-1:0];
  end

  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign out_valid = (cnt_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign sat       = sat_q;
  assign ovf_drop  = ovf_q;

endmodule
